// File: rtl/m10k_row_streamer_if.sv
// Memory-side and stream-side buses of the M10K row streamer.
// master = streamer, slave = row memory plus downstream sink.
interface m10k_row_streamer_if #(
  parameter int DATA_LEN     = 32,
  parameter int N            = 8,
  parameter int ADDRESS_SIZE = 4
);
  logic [ADDRESS_SIZE-1:0] o_address;
  logic                    o_wr_en;
  logic [DATA_LEN*N-1:0]   i_read_data;
  logic [DATA_LEN-1:0]     o_data;
  logic                    o_valid;
  logic                    i_ready;
  logic                    o_last;

  modport master (
    output o_address, o_wr_en, o_data, o_valid, o_last,
    input  i_read_data, i_ready
  );

  modport slave (
    input  o_address, o_wr_en, o_data, o_valid, o_last,
    output i_read_data, i_ready
  );
endinterface

// File: rtl/m10k_row_streamer.sv
// Streams consecutive rows of a registered-output M10K row memory as words
// over a valid/ready channel, word 0 of each row first.
module m10k_row_streamer #(
  parameter int DATA_LEN     = 32,
  parameter int N            = 8,
  parameter int ADDRESS_SIZE = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rstn,
  input  logic                    i_start,
  input  logic [ADDRESS_SIZE-1:0] i_base_addr,
  input  logic [ADDRESS_SIZE:0]   i_row_count,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [2:0]              o_state,
  m10k_row_streamer_if.master     bus
);
  localparam int                IDX_W    = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_WAIT = 3'd2,
    ST_SEND = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  state_t                  state_r;
  state_t                  next_s;
  logic [ADDRESS_SIZE-1:0] addr_r;
  logic [ADDRESS_SIZE:0]   rows_left_r;
  logic [DATA_LEN*N-1:0]   row_buf_r;
  logic [IDX_W-1:0]        idx_r;
  logic [DATA_LEN-1:0]     data_r;
  logic                    valid_r;
  logic                    last_r;
  logic                    busy_r;
  logic                    done_r;
  logic                    xfer_s;
  logic                    row_end_s;
  logic                    final_row_s;
  logic                    start_ok_s;
  logic [IDX_W-1:0]        idx_next_s;

  assign xfer_s      = valid_r & bus.i_ready;
  assign row_end_s   = xfer_s & (idx_r == LAST_IDX);
  assign final_row_s = (rows_left_r == (ADDRESS_SIZE+1)'(1));
  assign start_ok_s  = (i_row_count != {(ADDRESS_SIZE+1){1'b0}});
  assign idx_next_s  = idx_r + IDX_W'(1);

  assign bus.o_address = addr_r;
  assign bus.o_wr_en   = 1'b0;
  assign bus.o_data    = data_r;
  assign bus.o_valid   = valid_r;
  assign bus.o_last    = last_r;
  assign o_busy        = busy_r;
  assign o_done        = done_r;
  assign o_state       = state_r;

  // State register.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state decode; READ and WAIT cover the two-edge memory read latency.
  always_comb begin
    next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (i_start) begin
          next_s = start_ok_s ? ST_READ : ST_DONE;
        end else begin
          next_s = ST_IDLE;
        end
      end
      ST_READ: next_s = ST_WAIT;
      ST_WAIT: next_s = ST_SEND;
      ST_SEND: begin
        if (row_end_s) begin
          next_s = final_row_s ? ST_DONE : ST_READ;
        end else begin
          next_s = ST_SEND;
        end
      end
      ST_DONE: next_s = ST_IDLE;
      default: next_s = ST_IDLE;
    endcase
  end

  // Datapath: address/row counters, row buffer and the registered stream outputs.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      addr_r      <= {ADDRESS_SIZE{1'b0}};
      rows_left_r <= {(ADDRESS_SIZE+1){1'b0}};
      row_buf_r   <= {(DATA_LEN*N){1'b0}};
      idx_r       <= {IDX_W{1'b0}};
      data_r      <= {DATA_LEN{1'b0}};
      valid_r     <= 1'b0;
      last_r      <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      busy_r <= (next_s == ST_READ) || (next_s == ST_WAIT) || (next_s == ST_SEND);
      done_r <= (next_s == ST_DONE);
      case (state_r)
        ST_IDLE: begin
          if (i_start && start_ok_s) begin
            addr_r      <= i_base_addr;
            rows_left_r <= i_row_count;
          end
        end
        ST_WAIT: begin
          row_buf_r <= bus.i_read_data;
          idx_r     <= {IDX_W{1'b0}};
          data_r    <= bus.i_read_data[DATA_LEN-1:0];
          valid_r   <= 1'b1;
          last_r    <= final_row_s && (LAST_IDX == {IDX_W{1'b0}});
        end
        ST_SEND: begin
          if (row_end_s) begin
            valid_r <= 1'b0;
            last_r  <= 1'b0;
            if (!final_row_s) begin
              rows_left_r <= rows_left_r - (ADDRESS_SIZE+1)'(1);
              addr_r      <= addr_r + ADDRESS_SIZE'(1);
            end
          end else if (xfer_s) begin
            idx_r  <= idx_next_s;
            data_r <= row_buf_r[DATA_LEN*idx_next_s +: DATA_LEN];
            last_r <= final_row_s && (idx_next_s == LAST_IDX);
          end
        end
        default: begin
        end
      endcase
    end
  end
endmodule

// File: tb/tb_m10k_row_streamer.sv
// Scoreboard bench for m10k_row_streamer: a word-level model fills a queue of
// expected transfers at start; an independent monitor pops and compares.
module tb_m10k_row_streamer;
  localparam int DL = 32;
  localparam int NW = 8;
  localparam int AS = 4;

  logic          i_clk = 1'b0;
  logic          i_rstn;
  logic          i_start;
  logic [AS-1:0] i_base_addr;
  logic [AS:0]   i_row_count;
  logic          o_busy;
  logic          o_done;
  logic [2:0]    o_state;

  m10k_row_streamer_if #(.DATA_LEN(DL), .N(NW), .ADDRESS_SIZE(AS)) bus ();

  m10k_row_streamer #(.DATA_LEN(DL), .N(NW), .ADDRESS_SIZE(AS)) dut (
    .i_clk       (i_clk),
    .i_rstn      (i_rstn),
    .i_start     (i_start),
    .i_base_addr (i_base_addr),
    .i_row_count (i_row_count),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_state     (o_state),
    .bus         (bus)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [AS-1:0] addr;
    logic [DL-1:0] data;
    logic          last;
  } exp_t;

  exp_t    exp_q[$];
  int      vectors     = 0;
  int      miscompares = 0;
  int      done_cnt    = 0;
  int      xfer_cnt    = 0;
  int      gap_run     = 0;
  int      last_gap    = 0;
  bit      seen_xfer   = 1'b0;
  bit      held_v      = 1'b0;
  logic [DL-1:0] held_d;
  logic          held_l;

  // Preloaded memory contents: row r word j = 8r+j for rows 0-7, zero above.
  function automatic logic [DL-1:0] mem_word(input logic [AS-1:0] r, input int j);
    if (int'(r) < 8) return DL'(int'(r) * 8 + j);
    else return '0;
  endfunction

  function automatic logic [DL*NW-1:0] mem_row(input logic [AS-1:0] r);
    logic [DL*NW-1:0] v;
    v = '0;
    for (int j = 0; j < NW; j++) v[DL*j +: DL] = mem_word(r, j);
    return v;
  endfunction

  // Registered-output row memory.
  always @(posedge i_clk) begin
    if (!bus.o_wr_en) bus.i_read_data <= mem_row(bus.o_address);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: pops expected words on every transfer, checks stalls and gaps.
  initial begin
    exp_t e;
    forever begin
      @(negedge i_clk);
      if (!i_rstn) begin
        held_v  = 1'b0;
        gap_run = 0;
      end else begin
        if (o_done) done_cnt++;
        if (held_v) begin
          chk("hold_valid", bus.o_valid, 1);
          chk("hold_data", bus.o_data, held_d);
          chk("hold_last", bus.o_last, held_l);
        end
        if (seen_xfer && !bus.o_valid && exp_q.size() > 0) gap_run++;
        else if (bus.o_valid && gap_run > 0) begin
          last_gap = gap_run;
          gap_run  = 0;
        end
        if (bus.o_valid && exp_q.size() == 0) begin
          chk("spurious_valid", bus.o_valid, 0);
        end else if (bus.o_valid && bus.i_ready) begin
          e = exp_q.pop_front();
          chk("word_data", bus.o_data, e.data);
          chk("word_last", bus.o_last, e.last);
          chk("word_addr", bus.o_address, e.addr);
          xfer_cnt++;
          seen_xfer = 1'b1;
        end
        held_v = bus.o_valid && !bus.i_ready;
        held_d = bus.o_data;
        held_l = bus.o_last;
      end
    end
  end

  task automatic check_reset_values(input string tag);
    chk({tag, "_address"}, bus.o_address, 0);
    chk({tag, "_wr_en"}, bus.o_wr_en, 0);
    chk({tag, "_data"}, bus.o_data, 0);
    chk({tag, "_valid"}, bus.o_valid, 0);
    chk({tag, "_last"}, bus.o_last, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_state"}, o_state, 0);
  endtask

  function automatic void push_model(input int base, input int cnt);
    logic [AS-1:0] row;
    for (int r = 0; r < cnt; r++) begin
      row = AS'(base + r);
      for (int j = 0; j < NW; j++)
        exp_q.push_back('{addr: row, data: mem_word(row, j), last: (r == cnt - 1) && (j == NW - 1)});
    end
  endfunction

  // rmode: 0 ready always high, 1 pattern 1,0,0,1, 2 random.
  task automatic run_stream(input int base, input int cnt, input int rmode,
                            input bit check_gap, input bit poke);
    int            lat;
    int            extra;
    bit            poked;
    logic [AS-1:0] addr_before;
    done_cnt  = 0;
    seen_xfer = 1'b0;
    gap_run   = 0;
    last_gap  = 0;
    lat       = -1;
    extra     = 0;
    poked     = 1'b0;
    push_model(base, cnt);
    addr_before = bus.o_address;
    i_start     = 1'b1;
    i_base_addr = AS'(base);
    i_row_count = (AS+1)'(cnt);
    @(posedge i_clk); #1;
    i_start     = 1'b0;
    i_base_addr = AS'($urandom);
    i_row_count = (AS+1)'($urandom);
    for (int k = 1; k < 600; k++) begin
      case (rmode)
        0:       bus.i_ready = 1'b1;
        1:       bus.i_ready = ((k - 1) % 4 == 0) || ((k - 1) % 4 == 3);
        default: bus.i_ready = 1'($urandom_range(0, 1));
      endcase
      if (poke && !poked && bus.o_valid && o_state == 3'd3) begin
        i_start     = 1'b1;
        i_base_addr = AS'(5);
        i_row_count = (AS+1)'(2);
        poked       = 1'b1;
      end
      @(negedge i_clk);
      if (lat < 0 && bus.o_valid) lat = k - 1;
      if (poke && o_done) begin
        i_start     = 1'b1;
        i_base_addr = AS'(5);
      end
      @(posedge i_clk); #1;
      i_start = 1'b0;
      if (done_cnt > 0) extra++;
      if (extra >= 4) break;
    end
    chk("done_pulses", done_cnt, 1);
    chk("queue_drained", exp_q.size(), 0);
    if (cnt > 0) chk("first_valid_latency", lat, 2);
    else chk("addr_unchanged", bus.o_address, addr_before);
    if (check_gap) chk("row_gap", last_gap, 2);
    chk("end_state", o_state, 0);
    chk("end_busy", o_busy, 0);
    exp_q.delete();
  endtask

  task automatic reset_mid_stream();
    done_cnt  = 0;
    xfer_cnt  = 0;
    seen_xfer = 1'b0;
    push_model(1, 4);
    bus.i_ready = 1'b1;
    i_start     = 1'b1;
    i_base_addr = AS'(1);
    i_row_count = (AS+1)'(4);
    @(posedge i_clk); #1;
    i_start = 1'b0;
    for (int k = 0; k < 100 && xfer_cnt < 3; k++) @(negedge i_clk);
    chk("reach_third_word", xfer_cnt, 3);
    @(posedge i_clk); #2;
    i_rstn = 1'b0;
    #1;
    check_reset_values("midrst");
    exp_q.delete();
    repeat (3) @(posedge i_clk);
    #1;
    i_rstn = 1'b1;
    repeat (20) begin
      @(posedge i_clk); #1;
    end
    chk("no_xfer_after_reset", xfer_cnt, 3);
    chk("no_done_after_reset", done_cnt, 0);
    chk("idle_after_reset", o_state, 0);
  endtask

  initial begin
    i_rstn      = 1'b0;
    i_start     = 1'b0;
    i_base_addr = '0;
    i_row_count = '0;
    bus.i_ready = 1'b0;
    #12;
    check_reset_values("por");
    @(posedge i_clk); #1;
    i_rstn = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    run_stream(0, 1, 0, 1'b0, 1'b0);
    run_stream(2, 1, 1, 1'b0, 1'b0);
    run_stream(15, 2, 0, 1'b1, 1'b0);
    run_stream(3, 0, 0, 1'b0, 1'b0);
    run_stream(0, 3, 0, 1'b0, 1'b1);
    reset_mid_stream();
    run_stream(4, 2, 2, 1'b0, 1'b0);
    for (int t = 0; t < 6; t++)
      run_stream(int'($urandom_range(0, 15)), int'($urandom_range(0, 4)), 2, 1'b0, 1'b0);
    run_stream(6, 16, 2, 1'b0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
